// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter.
//   MNONE/MREAD/MWRITE/MILL : 2-bit RAM command encodings (MILL = illegal 11)
//   owner_t                 : current RAM port owner, also driven on the owner output
//   ram_cmd()               : maps a requester command onto the RAM command bus
package mem_port_arbiter_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;
    localparam logic [1:0] MILL   = 2'b11;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DMA  = 2'b10
    } owner_t;

    // The illegal encoding must never reach the RAM; it becomes a no-op.
    function automatic logic [1:0] ram_cmd(input logic [1:0] cmd);
        return (cmd == MILL) ? MNONE : cmd;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the RAM and the arbiter.
//   cpu_* / dma_*      : request side (req, cmd, addr, wdata, lock) and responses (gnt, rvalid)
//   rdata              : read data shared by both requesters
//   mem_*              : RAM command/address/write data and RAM read data
//   owner, cmd_err     : arbiter status
// Modports: slave = arbiter view, master = requester/RAM view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic [1:0]        cpu_cmd;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_lock;
    logic              cpu_gnt;
    logic              cpu_rvalid;

    logic              dma_req;
    logic [1:0]        dma_cmd;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;

    logic [DATA_W-1:0] rdata;
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        owner;
    logic              cmd_err;

    modport slave (
        input  cpu_req, cpu_cmd, cpu_addr, cpu_wdata, cpu_lock,
        input  dma_req, dma_cmd, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
        output rdata, mem_cmd, mem_addr, mem_wdata, owner, cmd_err
    );

    modport master (
        output cpu_req, cpu_cmd, cpu_addr, cpu_wdata, cpu_lock,
        output dma_req, dma_cmd, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid,
        input  rdata, mem_cmd, mem_addr, mem_wdata, owner, cmd_err
    );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational next-owner selection.
//   req_i  : {dma_req, cpu_req}
//   last_i : port granted most recently (including a grant happening this cycle)
//   hold_i : CPU lock run continues; overrides round robin
//   next_o : owner for the next cycle
module arb_rr_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_t     last_i,
    input  logic       hold_i,
    output owner_t     next_o
);

    always_comb begin
        next_o = OWN_NONE;
        if (hold_i) begin
            next_o = OWN_CPU;
        end else begin
            case (req_i)
                2'b01:   next_o = OWN_CPU;
                2'b10:   next_o = OWN_DMA;
                2'b11:   next_o = (last_i == OWN_CPU) ? OWN_DMA : OWN_CPU;
                default: next_o = OWN_NONE;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port synchronous RAM between the CPU and the DMA/loader port.
// Round-robin arbitration with a bounded CPU lock so fetch pairs stay back-to-back.
//   clk, rst_n : clock (rising edge), async active-low reset
//   bus        : mem_port_arbiter_if.slave (requests, grants, RAM side, status)
//   MAX_LOCK   : max consecutive locked CPU grants while the DMA is waiting (>=1)
//
// owner state | meaning
// ------------+-----------------------------------------------
// OWN_NONE    | nobody owns the RAM port, no grant possible
// OWN_CPU     | CPU request is granted whenever cpu_req is high
// OWN_DMA     | DMA request is granted whenever dma_req is high
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_LOCK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

    localparam int LOCK_W = $clog2(MAX_LOCK + 1);

    owner_t             owner_q, owner_d;
    owner_t             last_q, last_d;
    logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic               cpu_rvalid_q, cpu_rvalid_d;
    logic               dma_rvalid_q, dma_rvalid_d;
    logic               cmd_err_q, cmd_err_d;

    logic               cpu_gnt;
    logic               dma_gnt;
    logic               hold;
    owner_t             last_now;

    assign cpu_gnt = (owner_q == OWN_CPU) & bus.cpu_req;
    assign dma_gnt = (owner_q == OWN_DMA) & bus.dma_req;

    // Round robin must see the grant being taken this cycle, otherwise a
    // continuous dual request would hand the same port two grants in a row.
    assign last_now = cpu_gnt ? OWN_CPU : (dma_gnt ? OWN_DMA : last_q);

    // The lock only bounds CPU ownership while the DMA is actually waiting.
    assign hold = cpu_gnt & bus.cpu_lock &
                  (~bus.dma_req | (lock_cnt_q < LOCK_W'(MAX_LOCK - 1)));

    arb_rr_pick u_pick (
        .req_i  ({bus.dma_req, bus.cpu_req}),
        .last_i (last_now),
        .hold_i (hold),
        .next_o (owner_d)
    );

    always_comb begin
        last_d       = last_now;
        cpu_rvalid_d = cpu_gnt & (bus.cpu_cmd == MREAD);
        dma_rvalid_d = dma_gnt & (bus.dma_cmd == MREAD);
        cmd_err_d    = cmd_err_q |
                       (cpu_gnt & (bus.cpu_cmd == MILL)) |
                       (dma_gnt & (bus.dma_cmd == MILL));
        // Any grant outside a lock run ends the run, so the count restarts.
        lock_cnt_d   = '0;
        if (hold) begin
            lock_cnt_d = bus.dma_req ? (lock_cnt_q + LOCK_W'(1)) : lock_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q      <= OWN_NONE;
            last_q       <= OWN_DMA;
            lock_cnt_q   <= '0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            last_q       <= last_d;
            lock_cnt_q   <= lock_cnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dma_rvalid_q <= dma_rvalid_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    always_comb begin
        bus.mem_cmd   = MNONE;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (cpu_gnt) begin
            bus.mem_cmd   = ram_cmd(bus.cpu_cmd);
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (dma_gnt) begin
            bus.mem_cmd   = ram_cmd(bus.dma_cmd);
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
        end
    end

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.dma_gnt    = dma_gnt;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dma_rvalid = dma_rvalid_q;
    assign bus.rdata      = bus.mem_rdata;
    assign bus.owner      = owner_q;
    assign bus.cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    logic ram_init;
    int   total;
    int   bad;

    logic [15:0] ram [0:511];

    mem_port_arbiter_if #(.ADDR_W(9), .DATA_W(16)) bus ();

    mem_port_arbiter #(.MAX_LOCK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM model: write on MWRITE, read data the cycle after MREAD.
    always @(posedge clk) begin
        if (bus.mem_cmd == MWRITE)
            ram[bus.mem_addr] <= bus.mem_wdata;
        else if (ram_init)
            ram[9'h005] <= 16'hBEEF;
        if (bus.mem_cmd == MREAD)
            bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.cpu_req   = 1'b0;
        bus.cpu_cmd   = MNONE;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_lock  = 1'b0;
        bus.dma_req   = 1'b0;
        bus.dma_cmd   = MNONE;
        bus.dma_addr  = '0;
        bus.dma_wdata = '0;
    endtask

    task automatic do_reset();
        tick();
        idle_inputs();
        rst_n    = 1'b0;
        ram_init = 1'b1;
        tick();
        tick();
        ram_init = 1'b0;
        rst_n    = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] lock_pat;
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        ram_init = 1'b1;
        idle_inputs();

        // 1. reset state
        sample();
        chk("rst_owner",   32'(bus.owner), 32'h0);
        chk("rst_mem_cmd", 32'(bus.mem_cmd), 32'h0);
        chk("rst_gnts",    32'({bus.cpu_gnt, bus.dma_gnt}), 32'h0);
        chk("rst_rvalid",  32'({bus.cpu_rvalid, bus.dma_rvalid}), 32'h0);
        chk("rst_cmd_err", 32'(bus.cmd_err), 32'h0);

        // 1b. reset between grant and read return drops rvalid
        do_reset();
        bus.cpu_req  = 1'b1;
        bus.cpu_cmd  = MREAD;
        bus.cpu_addr = 9'h005;
        tick();
        sample();
        chk("midrd_gnt", 32'(bus.cpu_gnt), 32'h1);
        rst_n = 1'b0;
        idle_inputs();
        sample();
        chk("midrd_rvalid_in_rst", 32'(bus.cpu_rvalid), 32'h0);
        tick();
        rst_n = 1'b1;
        sample();
        chk("midrd_rvalid_after", 32'(bus.cpu_rvalid), 32'h0);

        // 2. CPU read of RAM[5]
        do_reset();
        bus.cpu_req  = 1'b1;
        bus.cpu_cmd  = MREAD;
        bus.cpu_addr = 9'h005;
        sample();
        chk("rd_no_gnt_cycle_n", 32'(bus.cpu_gnt), 32'h0);
        tick();
        sample();
        chk("rd_gnt_n1",    32'(bus.cpu_gnt), 32'h1);
        chk("rd_mem_cmd",   32'(bus.mem_cmd), 32'(MREAD));
        chk("rd_mem_addr",  32'(bus.mem_addr), 32'h005);
        tick();
        bus.cpu_req = 1'b0;
        sample();
        chk("rd_cpu_rvalid", 32'(bus.cpu_rvalid), 32'h1);
        chk("rd_rdata",      32'(bus.rdata), 32'hBEEF);
        chk("rd_dma_rvalid", 32'(bus.dma_rvalid), 32'h0);
        tick();
        sample();
        chk("rd_rvalid_one_cycle", 32'(bus.cpu_rvalid), 32'h0);

        // 3. dual requests, no lock: alternate CPU/DMA (MNONE no-ops)
        do_reset();
        bus.cpu_req = 1'b1;
        bus.dma_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            sample();
            chk("rr_owner",   32'(bus.owner), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_cpu_gnt", 32'(bus.cpu_gnt), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("rr_dma_gnt", 32'(bus.dma_gnt), (i % 2 == 0) ? 32'h0 : 32'h1);
        end
        chk("rr_nop_no_rvalid", 32'({bus.cpu_rvalid, bus.dma_rvalid}), 32'h0);

        // 4. locked CPU with DMA pending: CCCCD CCCCD
        do_reset();
        bus.cpu_req  = 1'b1;
        bus.cpu_lock = 1'b1;
        bus.dma_req  = 1'b1;
        lock_pat = 10'b1000010000;
        for (int k = 0; k < 10; k++) begin
            tick();
            sample();
            chk("lock_cpu_gnt", 32'(bus.cpu_gnt), lock_pat[k] ? 32'h0 : 32'h1);
            chk("lock_dma_gnt", 32'(bus.dma_gnt), lock_pat[k] ? 32'h1 : 32'h0);
        end

        // 5. DMA write then CPU read-back
        do_reset();
        bus.dma_req   = 1'b1;
        bus.dma_cmd   = MWRITE;
        bus.dma_addr  = 9'h010;
        bus.dma_wdata = 16'h1234;
        tick();
        sample();
        chk("wr_dma_gnt",   32'(bus.dma_gnt), 32'h1);
        chk("wr_mem_cmd",   32'(bus.mem_cmd), 32'(MWRITE));
        chk("wr_mem_addr",  32'(bus.mem_addr), 32'h010);
        chk("wr_mem_wdata", 32'(bus.mem_wdata), 32'h1234);
        tick();
        bus.dma_req  = 1'b0;
        bus.cpu_req  = 1'b1;
        bus.cpu_cmd  = MREAD;
        bus.cpu_addr = 9'h010;
        sample();
        chk("wr_no_rvalid",  32'(bus.dma_rvalid), 32'h0);
        chk("wr_drop_gnts",  32'({bus.cpu_gnt, bus.dma_gnt}), 32'h0);
        tick();
        sample();
        chk("rb_cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
        chk("rb_mem_cmd", 32'(bus.mem_cmd), 32'(MREAD));
        tick();
        bus.cpu_req = 1'b0;
        sample();
        chk("rb_rvalid", 32'(bus.cpu_rvalid), 32'h1);
        chk("rb_rdata",  32'(bus.rdata), 32'h1234);

        // 6. illegal command
        do_reset();
        bus.cpu_req = 1'b1;
        bus.cpu_cmd = MILL;
        tick();
        sample();
        chk("ill_gnt",     32'(bus.cpu_gnt), 32'h1);
        chk("ill_mem_cmd", 32'(bus.mem_cmd), 32'(MNONE));
        chk("ill_err_pre", 32'(bus.cmd_err), 32'h0);
        tick();
        bus.cpu_req = 1'b0;
        bus.cpu_cmd = MNONE;
        sample();
        chk("ill_err_set",   32'(bus.cmd_err), 32'h1);
        chk("ill_no_rvalid", 32'(bus.cpu_rvalid), 32'h0);
        tick();
        tick();
        sample();
        chk("ill_err_sticky", 32'(bus.cmd_err), 32'h1);
        do_reset();
        sample();
        chk("ill_err_cleared", 32'(bus.cmd_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
